// File: rtl/hazard_pkg.sv
// Shared hazard-unit definitions: widths, forward-select encoding,
// scoreboard entry layout and mult/div latency defaults.
package hazard_pkg;

  localparam int REG_AW       = 5;
  localparam int TW           = 2;
  localparam int NUM_STAGES_D = 3;
  localparam int SEL_W        = $clog2(NUM_STAGES_D + 1);
  localparam int MULT_LAT_D   = 5;
  localparam int DIV_LAT_D    = 10;
  localparam int FWD_RF       = 0;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] wa;
    logic [TW-1:0]     tnew;
  } sb_entry_t;

  function automatic int fwd_stage(input int k);
    return k + 1;
  endfunction

endpackage

// File: rtl/hazard_md_timer.sv
// Mult/div busy timer: loads the unit latency on an accepted start,
// otherwise counts down to zero. Busy while non-zero.
module hazard_md_timer
  import hazard_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_D,
  parameter int DIV_LAT  = DIV_LAT_D,
  localparam int MAXL    = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT,
  localparam int CW      = $clog2(MAXL + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_div,
  output logic o_busy
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// In-flight write scoreboard with Tuse/Tnew stall and forward select.
// Optional stall counter enabled by HAZARD_STALL_CNT_EN.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_D,
  parameter int MULT_LAT   = MULT_LAT_D,
  parameter int DIV_LAT    = DIV_LAT_D,
  localparam int SW        = $clog2(NUM_STAGES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic [TW-1:0]     d_rs_tuse,
  input  logic [TW-1:0]     d_rt_tuse,
  input  logic [REG_AW-1:0] d_wa,
  input  logic [TW-1:0]     d_tnew,
  input  logic              d_md_start,
  input  logic              d_md_div,
  input  logic              d_md_use,
  output logic              stall,
  output logic [SW-1:0]     fwd_rs_sel,
  output logic [SW-1:0]     fwd_rt_sel,
  output logic              md_busy,
  output logic [31:0]       stall_cnt
);

  sb_entry_t [NUM_STAGES-1:0] r_sb;

  logic          w_rs_hit, w_rt_hit;
  logic [SW-1:0] w_rs_k, w_rt_k;
  logic [TW-1:0] w_rs_tn, w_rt_tn;
  logic          w_rs_stall, w_rt_stall;
  logic          w_md_stall, w_md_load;

  // Scan oldest to youngest so the youngest match overrides.
  always_comb begin
    w_rs_hit = 1'b0;
    w_rs_k   = '0;
    w_rs_tn  = '0;
    w_rt_hit = 1'b0;
    w_rt_k   = '0;
    w_rt_tn  = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (r_sb[k].valid && r_sb[k].wa == d_rs) begin
        w_rs_hit = 1'b1;
        w_rs_k   = SW'(fwd_stage(k));
        w_rs_tn  = r_sb[k].tnew;
      end
      if (r_sb[k].valid && r_sb[k].wa == d_rt) begin
        w_rt_hit = 1'b1;
        w_rt_k   = SW'(fwd_stage(k));
        w_rt_tn  = r_sb[k].tnew;
      end
    end
    w_rs_hit = w_rs_hit && (d_rs != '0);
    w_rt_hit = w_rt_hit && (d_rt != '0);
  end

  assign w_rs_stall = w_rs_hit && (w_rs_tn > d_rs_tuse);
  assign w_rt_stall = w_rt_hit && (w_rt_tn > d_rt_tuse);
  assign w_md_stall = md_busy && d_md_use;

  assign stall = d_valid && (w_rs_stall || w_rt_stall || w_md_stall);

  assign fwd_rs_sel = (w_rs_hit && w_rs_tn == '0) ? w_rs_k : SW'(FWD_RF);
  assign fwd_rt_sel = (w_rt_hit && w_rt_tn == '0) ? w_rt_k : SW'(FWD_RF);

  assign w_md_load = d_md_start && d_valid && !stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sb <= '0;
    end else begin
      r_sb[0].valid <= d_valid && !stall && (d_wa != '0);
      r_sb[0].wa    <= d_wa;
      r_sb[0].tnew  <= d_tnew;
      for (int k = 1; k < NUM_STAGES; k++) begin
        r_sb[k].valid <= r_sb[k-1].valid;
        r_sb[k].wa    <= r_sb[k-1].wa;
        r_sb[k].tnew  <= (r_sb[k-1].tnew != '0) ?
                         r_sb[k-1].tnew - TW'(1) : '0;
      end
    end
  end

  hazard_md_timer #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_timer (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_md_load),
    .i_div  (d_md_div),
    .o_busy (md_busy)
  );

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (stall && r_stall_cnt != '1) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule
